// File: rtl/sigmoid_pipe.sv
// Three-stage streaming piecewise-linear sigmoid with valid/ready handshake.
// Mode 1 turns the same datapath into sigma(x)*(1-sigma(x)) for backprop.
module sigmoid_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {RegR0, RegR1, RegR2, RegR3} region_e;

  localparam logic [WIDTH-1:0] LP_LSB   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LP_ONE   = LP_LSB << FRAC;
  localparam logic [WIDTH-1:0] LP_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LP_C5    = (LP_ONE << 2) + LP_ONE;
  localparam logic [WIDTH-1:0] LP_C2375 = (LP_ONE << 1) + (LP_ONE >> 2) + (LP_ONE >> 3);
  localparam logic [WIDTH-1:0] LP_K0    = (LP_ONE >> 1) + (LP_ONE >> 2) + (LP_ONE >> 4)
                                        + (LP_ONE >> 5);
  localparam logic [WIDTH-1:0] LP_K1    = (LP_ONE >> 1) + (LP_ONE >> 3);
  localparam logic [WIDTH-1:0] LP_K2    = LP_ONE >> 1;

  logic             w_stall;
  logic             w_accept;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH-1:0] w_mag;
  region_e          w_region;

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [WIDTH-1:0] r_s1_mag;
  region_e          r_s1_region;
  logic             r_s1_mode;

  logic [WIDTH-1:0] w_y_raw;
  logic [WIDTH-1:0] w_y_sel;
  logic [WIDTH-1:0] w_y;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_y;
  logic             r_s2_mode;

  logic [WIDTH-1:0]   w_one_minus;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_deriv;
  logic [WIDTH-1:0]   w_s3_data;

  logic             r_s3_valid;
  logic [WIDTH-1:0] r_s3_data;

  assign w_stall   = r_s3_valid & ~out_ready;
  assign in_ready  = ~w_stall & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_s3_valid;
  assign out_data  = r_s3_data;
  assign busy      = r_s1_valid | r_s2_valid | r_s3_valid;

  // Negating the most negative value wraps back to itself; clamp it instead.
  assign w_neg = ~in_data + LP_LSB;

  always_comb begin
    w_mag    = in_data;
    w_region = RegR0;
    if (in_data[WIDTH-1]) begin
      w_mag = w_neg[WIDTH-1] ? LP_MAX : w_neg;
    end
    if (w_mag >= LP_C5) begin
      w_region = RegR3;
    end else if (w_mag >= LP_C2375) begin
      w_region = RegR2;
    end else if (w_mag >= LP_ONE) begin
      w_region = RegR1;
    end
  end

  always_comb begin
    w_y_raw = LP_ONE;
    unique case (r_s1_region)
      RegR3: w_y_raw = LP_ONE;
      RegR2: w_y_raw = (r_s1_mag >> 5) + LP_K0;
      RegR1: w_y_raw = (r_s1_mag >> 3) + LP_K1;
      RegR0: w_y_raw = (r_s1_mag >> 2) + LP_K2;
      default: w_y_raw = LP_ONE;
    endcase
    w_y_sel = r_s1_sign ? (LP_ONE - w_y_raw) : w_y_raw;
    w_y     = (w_y_sel == '0) ? LP_LSB : w_y_sel;
  end

  assign w_one_minus = LP_ONE - r_s2_y;
  assign w_prod      = {{WIDTH{1'b0}}, r_s2_y} * {{WIDTH{1'b0}}, w_one_minus};

  always_comb begin
    w_deriv   = WIDTH'(w_prod >> FRAC);
    w_s3_data = r_s2_y;
    if (r_s2_mode) begin
      w_s3_data = (w_deriv == '0) ? LP_LSB : w_deriv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_mag    <= '0;
      r_s1_region <= RegR0;
      r_s1_mode   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_y      <= '0;
      r_s2_mode   <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_s3_data   <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sign   <= in_data[WIDTH-1];
        r_s1_mag    <= w_mag;
        r_s1_region <= w_region;
        r_s1_mode   <= in_mode;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_y     <= w_y;
      r_s2_mode  <= r_s1_mode;
      r_s3_valid <= r_s2_valid;
      r_s3_data  <= w_s3_data;
    end
  end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Directed-vector bench for sigmoid_pipe: 32/16 main instance plus a 16/8 instance.
module tb_sigmoid_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] in_data16;
  logic        in_mode16;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] out_data16;
  logic        busy16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sigmoid_pipe #(.WIDTH(32), .FRAC(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  sigmoid_pipe #(.WIDTH(16), .FRAC(8)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_data   (in_data16),
    .in_mode   (in_mode16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_data  (out_data16),
    .busy      (busy16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample, report cycles until out_valid and the value seen.
  task automatic push_and_wait(input logic [31:0] x, input logic m,
                               output logic [31:0] got, output int lat);
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    step();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    got = out_data;
    step();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got v=%b busy=%b rdy=%b data=%h want 0 0 0 0",
               out_valid, busy, in_ready, out_data);
    end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_mode0();
    logic [31:0] xs [12];
    logic [31:0] ex [12];
    logic [31:0] got;
    int          lat;
    xs = '{32'h00010000, 32'h00000000, 32'h0002C000, 32'h00050000, 32'h00026000,
           32'h00025FFF, 32'h0004FFFF, 32'h0000FFFF, 32'hFFFE8000, 32'hFFFF0000,
           32'hFFFA0000, 32'h80000000};
    ex = '{32'h0000C000, 32'h00008000, 32'h0000EE00, 32'h00010000, 32'h0000EB00,
           32'h0000EBFF, 32'h0000FFFF, 32'h0000BFFF, 32'h00003000, 32'h00004000,
           32'h00000001, 32'h00000001};
    for (int i = 0; i < 12; i++) begin
      push_and_wait(xs[i], 1'b0, got, lat);
      total++;
      if (got !== ex[i] || lat != 3) begin
        bad++;
        $display("FAIL mode0[%0d] x=%h: got %h lat=%0d want %h lat=3", i, xs[i], got, lat, ex[i]);
      end
    end
  endtask

  task automatic test_deriv();
    logic [31:0] xs [5];
    logic [31:0] ex [5];
    logic [31:0] got;
    int          lat;
    xs = '{32'h00010000, 32'h00000000, 32'h00050000, 32'hFFFF0000, 32'h00008000};
    ex = '{32'h00003000, 32'h00004000, 32'h00000001, 32'h00003000, 32'h00003C00};
    for (int i = 0; i < 5; i++) begin
      push_and_wait(xs[i], 1'b1, got, lat);
      total++;
      if (got !== ex[i] || lat != 3) begin
        bad++;
        $display("FAIL deriv[%0d] x=%h: got %h lat=%0d want %h lat=3", i, xs[i], got, lat, ex[i]);
      end
    end
  endtask

  // Alternating modes, one sample per cycle, pop and push every cycle.
  task automatic test_back_to_back();
    logic [31:0] xs [6];
    logic        ms [6];
    logic [31:0] ex [6];
    xs = '{32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 32'h00050000,
           32'h00050000};
    ms = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ex = '{32'h0000C000, 32'h00003000, 32'h00008000, 32'h00004000, 32'h00010000,
           32'h00000001};
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 6);
      if (i < 6) begin
        in_data = xs[i];
        in_mode = ms[i];
      end
      step();
      if (i >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== ex[i-2]) begin
          bad++;
          $display("FAIL b2b[%0d]: got v=%b data=%h want v=1 data=%h",
                   i - 2, out_valid, out_data, ex[i-2]);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] xs [8];
    logic [31:0] ex [8];
    logic [31:0] held;
    int          sent;
    int          recv;
    held = '0;
    sent = 0;
    recv = 0;
    xs = '{32'h00010000, 32'h00000000, 32'h0002C000, 32'h00050000, 32'hFFFE8000,
           32'hFFFF0000, 32'h00008000, 32'h00020000};
    ex = '{32'h0000C000, 32'h00008000, 32'h0000EE00, 32'h00010000, 32'h00003000,
           32'h00004000, 32'h0000A000, 32'h0000E000};
    for (int c = 0; c < 60 && recv < 8; c++) begin
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? xs[sent] : 32'h0;
      in_mode   = 1'b0;
      out_ready = !(c >= 4 && c <= 9);
      #1;
      if (c == 4) begin
        held = out_data;
        total++;
        if (out_valid !== 1'b1 || out_data !== ex[1]) begin
          bad++;
          $display("FAIL bp_stall_entry: got v=%b data=%h want v=1 data=%h",
                   out_valid, out_data, ex[1]);
        end
      end
      if (c >= 4 && c <= 9) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
          bad++;
          $display("FAIL bp_stall[c=%0d]: got rdy=%b v=%b data=%h want rdy=0 v=1 data=%h",
                   c, in_ready, out_valid, out_data, held);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== ex[recv] || busy !== 1'b1) begin
          bad++;
          $display("FAIL bp_order[%0d]: got %h busy=%b want %h busy=1",
                   recv, out_data, busy, ex[recv]);
        end
        recv++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (recv != 8 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: got recv=%0d busy=%b v=%b want recv=8 busy=0 v=0",
               recv, busy, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] got;
    int          lat;
    out_ready = 1'b1;
    in_mode   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h00010000;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_fill: got v=%b busy=%b want v=1 busy=1", out_valid, busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_flush: got v=%b busy=%b rdy=%b data=%h want 0 0 0 0",
               out_valid, busy, in_ready, out_data);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_release: got v=%b busy=%b want 0 0", out_valid, busy);
    end
    push_and_wait(32'h0002C000, 1'b0, got, lat);
    total++;
    if (got !== 32'h0000EE00 || lat != 3) begin
      bad++;
      $display("FAIL rst_mid_first: got %h lat=%0d want 0000ee00 lat=3", got, lat);
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0] xs [3];
    logic        ms [3];
    logic [15:0] ex [3];
    logic [15:0] got;
    int          lat;
    xs = '{16'h0100, 16'hFE80, 16'h0100};
    ms = '{1'b0, 1'b0, 1'b1};
    ex = '{16'h00C0, 16'h0030, 16'h0030};
    out_ready16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid16 = 1'b1;
      in_data16  = xs[i];
      in_mode16  = ms[i];
      step();
      in_valid16 = 1'b0;
      lat = 1;
      while (!out_valid16 && lat < 10) begin
        step();
        lat++;
      end
      got = out_data16;
      step();
      total++;
      if (got !== ex[i] || lat != 3) begin
        bad++;
        $display("FAIL sweep16[%0d] x=%h: got %h lat=%0d want %h lat=3", i, xs[i], got, lat, ex[i]);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_mode     = 1'b0;
    out_ready   = 1'b1;
    in_valid16  = 1'b0;
    in_data16   = '0;
    in_mode16   = 1'b0;
    out_ready16 = 1'b1;
    test_reset();
    test_mode0();
    test_deriv();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
